// File: rtl/sparse_stream_decompressor_pkg.sv
// -----------------------------------------------------------------------------
// sparse_decomp_pkg
// Shared types and constants for the sparse stream decompressor.
//   state_t           : frame controller states (IDLE, RUN, DONE)
//   FLAG_ZERO/FLAG_VAL: token flag encodings
//   BW / FW           : bit-window width and fill-counter width for the
//                       default input word width; win_bits()/fill_bits()
//                       give the same values for any word width.
// -----------------------------------------------------------------------------
package sparse_decomp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic FLAG_ZERO = 1'b0;
    localparam logic FLAG_VAL  = 1'b1;

    localparam int DEF_IW = 64;
    localparam int BW     = 2 * DEF_IW;
    localparam int FW     = $clog2(BW + 1);

    // Window width for an input word width of iw bits.
    function automatic int win_bits(input int iw);
        return 2 * iw;
    endfunction

    // Fill counter width able to hold 0..2*iw.
    function automatic int fill_bits(input int iw);
        return $clog2(2 * iw + 1);
    endfunction

endpackage

// File: rtl/sparse_stream_decompressor_if.sv
// -----------------------------------------------------------------------------
// sparse_stream_decompressor_if
// Word input stream and value output stream of the decompressor.
//   in_valid/in_ready/in_data              : IW-bit bitstream words
//   out_valid/out_ready/out_data/out_last  : DW-bit decoded values
// Modports:
//   master : environment side (drives words, accepts values)
//   slave  : decompressor side
// -----------------------------------------------------------------------------
interface sparse_stream_decompressor_if #(
    parameter int DW = 16,
    parameter int IW = 64
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sparse_stream_decompressor_bit_window_buffer.sv
// -----------------------------------------------------------------------------
// bit_window_buffer
// MSB-aligned bit window of BW bits with a fill count.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : discard all buffered bits
//   append_en    : write append_data directly below the current fill bits
//   append_data  : IW-bit word, MSB-first
//   consume_n    : number of bits to drop from the top this cycle
//   peek         : top PW bits of the window
//   fill         : number of valid bits in the window
// Append and consume in the same cycle both use the pre-consume fill.
// Bits below fill are kept at zero so an append can be OR-merged.
// -----------------------------------------------------------------------------
module bit_window_buffer #(
    parameter int IW = 64,
    parameter int PW = 17,
    parameter int BW = 128,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          append_en,
    input  logic [IW-1:0] append_data,
    input  logic [FW-1:0] consume_n,
    output logic [PW-1:0] peek,
    output logic [FW-1:0] fill
);
    logic [BW-1:0] win_r;
    logic [BW-1:0] merged_s;
    logic [BW-1:0] win_next_s;
    logic [FW-1:0] fill_r;
    logic [FW-1:0] fill_next_s;

    // Merge an incoming word below the valid bits, then drop consumed bits.
    always_comb begin
        merged_s    = win_r;
        fill_next_s = fill_r - consume_n;
        if (append_en) begin
            merged_s    = win_r | ({append_data, {(BW-IW){1'b0}}} >> fill_r);
            fill_next_s = fill_r - consume_n + FW'(IW);
        end else begin
            merged_s    = win_r;
            fill_next_s = fill_r - consume_n;
        end
        win_next_s = merged_s << consume_n;
    end

    // Window and fill registers.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            win_r  <= '0;
            fill_r <= '0;
        end else begin
            win_r  <= win_next_s;
            fill_r <= fill_next_s;
        end
    end

    assign peek = win_r[BW-1 -: PW];
    assign fill = fill_r;
endmodule

// File: rtl/sparse_stream_decompressor.sv
// -----------------------------------------------------------------------------
// sparse_stream_decompressor
// Expands a flag-coded sparse bitstream into DW-bit values. A 0 flag gives a
// zero value, a 1 flag is followed by a DW-bit literal.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse, starts a frame when idle
//   frame_len  : elements in the frame, sampled on start
//   busy       : frame in progress
//   done       : one-cycle pulse at frame end
//   bus        : word input / value output streams (slave modport)
// Optional feature macro: SPARSE_DECOMP_RLE_EN -- a 0 flag is followed by a
// ZRW-bit count r and emits r+1 zeros; runs are truncated at frame end.
// -----------------------------------------------------------------------------
module sparse_stream_decompressor
    import sparse_decomp_pkg::*;
#(
    parameter int DW  = 16,
    parameter int IW  = 64,
    parameter int LW  = 16,
    parameter int ZRW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] frame_len,
    output logic          busy,
    output logic          done,
    sparse_stream_decompressor_if.slave bus
);
    localparam int WB = win_bits(IW);
    localparam int FB = fill_bits(IW);
    // Peek must cover a literal token and a run token, whichever is wider.
    localparam int PW = (DW + 1 > ZRW + 1) ? DW + 1 : ZRW + 1;

    state_t        state_r;
    state_t        state_next_s;
    logic [LW-1:0] len_r;
    logic [LW-1:0] cnt_r;          // values loaded into the output register
    logic          out_valid_r;
    logic          out_last_r;
    logic [DW-1:0] out_data_r;

    logic [PW-1:0] peek_s;
    logic [FB-1:0] fill_s;
    logic [FB-1:0] consume_s;
    logic          in_hs_s;
    logic          last_hs_s;
    logic          slot_free_s;
    logic          more_s;
    logic          dec_fire_s;
    logic [DW-1:0] dec_data_s;
`ifdef SPARSE_DECOMP_RLE_EN
    logic [ZRW-1:0] run_r;         // zeros still owed by the current run
    logic [ZRW-1:0] run_next_s;
`endif

    assign bus.in_ready = (state_r == RUN) && (fill_s <= FB'(IW));
    assign in_hs_s      = bus.in_valid && bus.in_ready;
    assign last_hs_s    = (state_r == RUN) && out_valid_r && bus.out_ready && out_last_r;
    assign slot_free_s  = !out_valid_r || bus.out_ready;
    assign more_s       = (cnt_r != len_r);

    bit_window_buffer #(
        .IW (IW),
        .PW (PW),
        .BW (WB),
        .FW (FB)
    ) u_window (
        .clk         (clk),
        .rst         (rst),
        .clear       (last_hs_s),
        .append_en   (in_hs_s),
        .append_data (bus.in_data),
        .consume_n   (consume_s),
        .peek        (peek_s),
        .fill        (fill_s)
    );

    // Token decode: at most one value per cycle when the output slot frees.
    always_comb begin
        dec_fire_s = 1'b0;
        dec_data_s = '0;
        consume_s  = '0;
`ifdef SPARSE_DECOMP_RLE_EN
        run_next_s = run_r;
`endif
        if ((state_r == RUN) && slot_free_s && more_s) begin
`ifdef SPARSE_DECOMP_RLE_EN
            if (run_r != '0) begin
                dec_fire_s = 1'b1;
                run_next_s = run_r - ZRW'(1);
            end else if ((fill_s >= FB'(ZRW + 1)) && (peek_s[PW-1] == FLAG_ZERO)) begin
                dec_fire_s = 1'b1;
                consume_s  = FB'(ZRW + 1);
                run_next_s = peek_s[PW-2 -: ZRW];
            end else if ((fill_s >= FB'(DW + 1)) && (peek_s[PW-1] == FLAG_VAL)) begin
                dec_fire_s = 1'b1;
                dec_data_s = peek_s[PW-2 -: DW];
                consume_s  = FB'(DW + 1);
            end else begin
                dec_fire_s = 1'b0;
            end
`else
            if ((fill_s >= FB'(1)) && (peek_s[PW-1] == FLAG_ZERO)) begin
                dec_fire_s = 1'b1;
                consume_s  = FB'(1);
            end else if ((fill_s >= FB'(DW + 1)) && (peek_s[PW-1] == FLAG_VAL)) begin
                dec_fire_s = 1'b1;
                dec_data_s = peek_s[PW-2 -: DW];
                consume_s  = FB'(DW + 1);
            end else begin
                dec_fire_s = 1'b0;
            end
`endif
        end else begin
            dec_fire_s = 1'b0;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (frame_len == '0) ? DONE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_hs_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Frame length latch, element count and run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r <= '0;
            cnt_r <= '0;
`ifdef SPARSE_DECOMP_RLE_EN
            run_r <= '0;
`endif
        end else if ((state_r == IDLE) && start) begin
            len_r <= frame_len;
            cnt_r <= '0;
`ifdef SPARSE_DECOMP_RLE_EN
            run_r <= '0;
`endif
        end else if (last_hs_s) begin
            // Leftover run zeros beyond the frame are dropped here.
            cnt_r <= '0;
`ifdef SPARSE_DECOMP_RLE_EN
            run_r <= '0;
`endif
        end else begin
            if (dec_fire_s) begin
                cnt_r <= cnt_r + LW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
`ifdef SPARSE_DECOMP_RLE_EN
            run_r <= run_next_s;
`endif
        end
    end

    // Output register; data and last hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (dec_fire_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= dec_data_s;
            out_last_r  <= (cnt_r == len_r - LW'(1));
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign busy          = (state_r == RUN);
    assign done          = (state_r == DONE);
endmodule

// File: doc/sparse_stream_decompressor.md
Name: sparse_stream_decompressor

Overview:
Parametrised successor to the weight-stream decompressor. Expands a flag-coded sparse bitstream into a stream of DW-bit values, one per element. The bitstream arrives as IW-bit words; a 0 flag means one zero value, and a 1 flag is followed by a DW-bit literal. The block sits between the off-chip weight fetch (valid/ready words) and the PE weight-load path (valid/ready values). It has explicit frame control, backpressure on both sides, and a 2*IW-bit bit window.

Parameters:
DW, 16, output value width (bits per literal)
IW, 64, input word width; requires DW+1 <= IW
LW, 16, width of frame_len (elements per frame)
ZRW, 4, zero-run field width (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; starts a frame when idle
frame_len  in  LW  elements in the frame; sampled on start
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse at frame end
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
in_data  in  IW  bitstream word, consumed MSB-first
out_valid  out  1  decoded value valid
out_ready  in  1  downstream accepts the value
out_data  out  DW  decoded value
out_last  out  1  marks the final element of the frame

Behaviour:
- Reset: state=IDLE. All of these clear to 0: fill, element count, busy, done, in_ready, out_valid, out_data, out_last. Reset mid-frame aborts the frame and discards the buffered bits. No done pulse is issued for an aborted frame.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start; latch frame_len.
  - IDLE -> DONE on start when frame_len==0.
  - RUN -> DONE on the out handshake of the element with out_last=1.
  - DONE -> IDLE after one cycle; done=1 during DONE.
- start while not IDLE is ignored. busy=1 in RUN.
- Bit window: buf is 2*IW bits, MSB-aligned; fill ranges 0..2*IW.
  - in_ready = (state==RUN) && (fill <= IW). This is registered-state only; there is no combinational path from out_ready.
  - An accepted word is written directly below the current fill bits.
- Decode happens in RUN when the window holds a complete token and the output slot is free (out_valid==0 or out_ready==1):
  - buf[MSB]==0: emit 0; consume 1 bit.
  - buf[MSB]==1 and fill>=DW+1: emit buf[MSB-1 -: DW]; consume DW+1 bits.
  - Otherwise the token is incomplete; wait with no output.
- Same-cycle append and consume: fill_next = fill - consumed + (in handshake ? IW : 0). The shift and the append use the pre-consume fill.
- Throughput and latency:
  - At most one token is decoded per cycle; one value per cycle sustained when out_ready=1 and bits are available.
  - A token whose bits were written at edge N is decoded in cycle N+1, and out_valid rises at edge N+1.
- Output registers: out_data and out_last are held stable while out_valid && !out_ready.
- out_last=1 on the value whose index equals frame_len-1.
- Frame end: residual window bits (padding) are discarded and fill is cleared when entering DONE. Frames always start word-aligned.
- Element count wraps are impossible because the count is compared against the latched frame_len, which is LW bits.

Optional Feature:
SPARSE_DECOMP_RLE_EN
- Defined: a 0 flag is followed by a ZRW-bit field r. The token consumes 1+ZRW bits and emits r+1 zero values, one per cycle.
  - A run extending past frame_len is truncated at the last element; the excess zeros are dropped.
  - A run in progress blocks new decode until it completes.
- Undefined: a 0 flag emits exactly one zero and consumes 1 bit; ZRW is unused.

Decomposition:
- Package sparse_decomp_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - FLAG_ZERO=1'b0 and FLAG_VAL=1'b1;
  - helper constants BW=2*IW and FW=$clog2(BW+1).
- One sub-module: bit_window_buffer. It owns buf and fill and provides append, consume-N, the peek of the top DW+1 bits, and the fill output. Decode, frame control and the output register stay in the top module.

Test Plan:
1. DW=16, IW=64, frame_len=4. Word MSB-first = 1,0x0005, 0, 0, 1,0x8001, then zero padding; out_ready=1. -> Outputs 0x0005, 0x0000, 0x0000, 0x8001 on consecutive cycles; out_last only on 0x8001; done pulses one cycle after the last handshake; busy then 0.
2. frame_len=64, one all-zero word. -> 64 zeros, one per cycle; exactly one word accepted; in_ready stays low while fill>64.
3. frame_len=4, four literals 0x1111, 0x2222, 0x3333, 0x4444 (68 bits over two words). -> The fourth literal straddles the word boundary and decodes correctly after the second word is accepted.
4. Test plan 1 with out_ready toggling 1,0,0,1,... -> out_data and out_last are stable while stalled; no value is lost or duplicated.
5. Two cases:
   - start with frame_len=0 -> done at the edge after start; in_ready never asserts.
   - rst asserted mid-frame -> the next cycle shows all outputs 0 and state IDLE; a following frame from test plan 1 decodes correctly.
6. With SPARSE_DECOMP_RLE_EN, ZRW=4, frame_len=10, stream = 0,0111, then 1,0x00AB, then 0,1111. -> 8 zeros, then 0x00AB, then 1 zero with out_last=1; the remaining 15 zeros of the run are dropped; done pulses.
